// File: rtl/branch_pc_pkg.sv
// Shared encodings for the branch/PC stage: branch opcodes, FSM states and
// the default reset and exception fetch addresses.
package branch_pc_pkg;

  localparam logic [1:0] BR_COND = 2'b00;
  localparam logic [1:0] BR_J    = 2'b01;
  localparam logic [1:0] BR_JR   = 2'b10;
  localparam logic [1:0] BR_RSV  = 2'b11;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h8000_0180;

endpackage

// File: rtl/branch_pc_br_target.sv
// Combinational branch decision: whether the instruction in EX redirects
// fetch, and the address it redirects to.
module br_target
  import branch_pc_pkg::*;
(
  input  logic        br_valid,
  input  logic [1:0]  br_op,
  input  logic        cond,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_off,
  input  logic [25:0] j_target,
  input  logic [31:0] jr_addr,
  output logic        taken,
  output logic [31:0] target
);

  logic        [31:0] pc_plus4;
  logic signed [31:0] off_ext;

  assign pc_plus4 = br_pc + 32'd4;
  // Word offset: sign-extend the immediate and scale to bytes.
  assign off_ext  = {{14{br_off[15]}}, br_off, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    case (br_op)
      BR_COND: begin
        taken  = br_valid & cond;
        target = pc_plus4 + $unsigned(off_ext);
      end
      BR_J: begin
        taken  = br_valid;
        target = {pc_plus4[31:28], j_target, 2'b00};
      end
      BR_JR: begin
        taken  = br_valid;
        target = jr_addr & 32'hFFFF_FFFC;
      end
      BR_RSV: begin
        taken  = 1'b0;
        target = pc_plus4;
      end
      default: begin
        taken  = 1'b0;
        target = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/branch_pc.sv
// PC register with branch redirect, one-entry pending redirect for branches
// resolved under stall, exception redirect and a saturating taken counter.
module branch_pc
  import branch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Exc,
  input  logic        BrValid,
  input  logic [1:0]  BrOp,
  input  logic        Cond,
  input  logic [31:0] BrPc,
  input  logic [15:0] BrOff,
  input  logic [25:0] JTarget,
  input  logic [31:0] JrAddr,
  output logic [31:0] PC,
  output logic        Flush,
  output logic [15:0] TakenCnt
);

  logic        taken;
  logic [31:0] target;
  logic [31:0] pend_tgt;
  logic [0:0]  state;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  br_target u_br_target (
    .br_valid (BrValid),
    .br_op    (BrOp),
    .cond     (Cond),
    .br_pc    (BrPc),
    .br_off   (BrOff),
    .j_target (JTarget),
    .jr_addr  (JrAddr),
    .taken    (taken),
    .target   (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC       <= RESET_PC;
      Flush    <= 1'b0;
      TakenCnt <= 16'd0;
      state    <= ST_RUN;
      pend_tgt <= 32'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (Exc) begin
            PC    <= EXC_PC;
            Flush <= 1'b1;
          end else if (taken && !Stall) begin
            PC       <= target;
            Flush    <= 1'b1;
            TakenCnt <= sat_inc(TakenCnt);
          end else if (taken) begin
            // Branch resolved while stalled: park the target until release.
            pend_tgt <= target;
            Flush    <= 1'b0;
            state    <= ST_PEND;
          end else if (Stall) begin
            Flush <= 1'b0;
          end else begin
            PC    <= PC + 32'd4;
            Flush <= 1'b0;
          end
        end
        ST_PEND: begin
          // New branches are ignored here; the parked redirect owns this slot.
          if (Exc) begin
            PC    <= EXC_PC;
            Flush <= 1'b1;
            state <= ST_RUN;
          end else if (Stall) begin
            Flush <= 1'b0;
          end else begin
            PC       <= pend_tgt;
            Flush    <= 1'b1;
            TakenCnt <= sat_inc(TakenCnt);
            state    <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
          Flush <= 1'b0;
        end
      endcase
    end
  end

endmodule
